// File: rtl/score_display_pkg.sv
// score_display_pkg: shared types, constants and helpers for the score display
package score_display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int NUM_DIGITS = 5;
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction
  function automatic logic [19:0] add3(input logic [19:0] a);
    logic [19:0] r;
    for (int i = 0; i < NUM_DIGITS; i++)
      r[i*4 +: 4] = a[i*4 +: 4] >= 4'd5 ? a[i*4 +: 4] + 4'd3 : a[i*4 +: 4];
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter committing all five digits at once
module bin2bcd_seq
  import score_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bin,
  output logic        busy,
  output logic [19:0] bcd
);
  state_t state;
  logic [1:0] rst_sync;
  logic [15:0] sreg, cap, last_score;
  logic [19:0] acc, acc_adj;
  logic [3:0] cnt;
  assign acc_adj = add3(acc);
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  // cap keeps the original value because sreg is consumed by the shifting
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      bcd <= '0;
      sreg <= '0;
      cap <= '0;
      last_score <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE:
          if (rst_sync[1] && bin != last_score) begin
            sreg <= bin;
            cap <= bin;
            acc <= '0;
            cnt <= '0;
            busy <= 1'b1;
            state <= SHIFT;
          end
        SHIFT: begin
          {acc, sreg} <= {acc_adj[18:0], sreg, 1'b0};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            busy <= 1'b0;
            state <= COMMIT;
          end
        end
        COMMIT: begin
          bcd <= acc;
          last_score <= cap;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/score_display.sv
// score_display: binary score to BCD plus multiplexed seven-segment scanner
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] score,
  output logic [19:0] bcd,
  output logic        busy,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] rcnt;
  logic [2:0] idx, idx_n;
  logic wrap, load, blank;
  logic [3:0] nib;
  bin2bcd_seq u_conv (
    .clk(clk),
    .rst(rst),
    .bin(score),
    .busy(busy),
    .bcd(bcd)
  );
  assign dp = 1'b1;
  // an==FF only right after reset; loading then starts a full first dwell
  always_comb begin
    wrap = rcnt == CW'(REFRESH_DIV - 1);
    load = wrap || an == 8'hFF;
    idx_n = wrap ? (idx == 3'(NUM_DIGITS - 1) ? 3'd0 : idx + 3'd1) : idx;
    nib = 4'(bcd >> {idx_n, 2'b00});
    blank = BLANK_LZ && idx_n != 3'd0 && (bcd >> {idx_n, 2'b00}) == 20'd0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rcnt <= '0;
      idx <= '0;
      an <= 8'hFF;
      seg <= SEG_BLANK;
    end else begin
      rcnt <= load ? '0 : rcnt + CW'(1);
      idx <= idx_n;
      if (load) begin
        an <= {3'b111, ~(5'b1 << idx_n)};
        seg <= blank ? SEG_BLANK : seg_decode(nib);
      end
    end
endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed vector bench for the score display
module tb_score_display;
  logic clk = 1'b0, rst = 1'b0;
  logic [15:0] score = '0;
  logic [19:0] bcd, bcd_nb;
  logic busy, busy_nb, dp, dp_nb;
  logic [7:0] an, an_nb;
  logic [6:0] seg, seg_nb;
  int n_cmp = 0, n_err = 0;
  logic [19:0] cur_bcd = '0;
  typedef struct {
    logic [15:0] score;
    logic [19:0] bcd;
    logic [4:0][6:0] segs;
  } vec_t;
  vec_t vecs [7];
  always #5 clk = ~clk;
  score_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .score(score), .bcd(bcd), .busy(busy),
    .an(an), .seg(seg), .dp(dp)
  );
  score_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .score(score), .bcd(bcd_nb), .busy(busy_nb),
    .an(an_nb), .seg(seg_nb), .dp(dp_nb)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_busy();
    bit seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      seen = busy;
    end
    chk("busy_rise", seen, 1);
  endtask
  task automatic run_conv(input logic [15:0] s, input logic [19:0] exp);
    int n = 1;
    @(negedge clk);
    score = s;
    wait_busy();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("busy_len", n, 16);
    chk("bcd_hold", bcd, cur_bcd);
    @(negedge clk);
    chk("bcd_commit", bcd, exp);
    chk("bcd_nb", bcd_nb, exp);
    cur_bcd = exp;
  endtask
  task automatic check_frame(input logic [4:0][6:0] exp, input bit nb);
    logic [6:0] got [5];
    logic [7:0] a;
    int bad = 0;
    bit hit;
    for (int d = 0; d < 5; d++) got[d] = 7'h55;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a = nb ? an_nb : an;
      hit = 1'b0;
      for (int d = 0; d < 5; d++)
        if (a == {3'b111, ~(5'b1 << d)}) begin
          got[d] = nb ? seg_nb : seg;
          hit = 1'b1;
        end
      if (!hit || (nb ? dp_nb : dp) !== 1'b1) bad++;
    end
    chk(nb ? "an_valid_nb" : "an_valid", bad, 0);
    for (int d = 0; d < 5; d++)
      chk($sformatf("seg_d%0d%s", d, nb ? "_nb" : ""), got[d], exp[d]);
  endtask
  initial begin
    int bad;
    bit found;
    vecs[0] = '{16'd12345, 20'h12345, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}};
    vecs[1] = '{16'd65535, 20'h65535, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12}};
    vecs[2] = '{16'd100, 20'h00100, {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[3] = '{16'd9, 20'h00009, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10}};
    vecs[4] = '{16'd10000, 20'h10000, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[5] = '{16'd808, 20'h00808, {7'h7F, 7'h7F, 7'h00, 7'h40, 7'h00}};
    vecs[6] = '{16'd67, 20'h00067, {7'h7F, 7'h7F, 7'h7F, 7'h02, 7'h78}};
    repeat (3) @(negedge clk);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_bcd", bcd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dp", dp, 1);
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("scan_an_%0d", k), an, {3'b111, ~(5'b1 << (k / 4))});
      chk($sformatf("scan_seg_%0d", k), seg, k < 4 ? 7'h40 : 7'h7F);
      if (busy) bad++;
    end
    chk("idle_busy", bad, 0);
    for (int v = 0; v < 7; v++) begin
      run_conv(vecs[v].score, vecs[v].bcd);
      check_frame(vecs[v].segs, 1'b0);
    end
    @(negedge clk);
    score = 16'd7;
    wait_busy();
    repeat (4) @(negedge clk);
    score = 16'd9;
    repeat (13) @(negedge clk);
    chk("chg_first", bcd, 20'h00007);
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 0) chk("chg_rebusy", busy, 1);
      if (bcd !== 20'h00007 && bcd !== 20'h00009) bad++;
    end
    @(negedge clk);
    chk("chg_second", bcd, 20'h00009);
    chk("chg_glitch", bad, 0);
    repeat (3) @(negedge clk);
    score = 16'd500;
    wait_busy();
    repeat (7) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_bcd", bcd, 0);
    chk("arst_busy", busy, 0);
    chk("arst_an", an, 8'hFF);
    chk("arst_seg", seg, 7'h7F);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bcd === 20'h00500;
    end
    chk("arst_recover", found, 1);
    cur_bcd = 20'h00500;
    run_conv(16'd42, 20'h00042);
    check_frame({7'h40, 7'h40, 7'h40, 7'h19, 7'h24}, 1'b1);
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/score_display.md
# score_display

Sequential binary-to-BCD converter and 8-digit seven-segment scanner for the Nexys-4 board.
- Consumes the 16-bit `score` produced by `block_controller` and shows it in decimal on the on-board display.
- Sits directly downstream of the game controller in the top level and shares its 100 MHz clock.
- Conversion is iterative (shift/add-3, one bit per cycle) and digits are committed atomically, so the display never shows a half-converted value.

## Interface
Parameters:
- `REFRESH_DIV`, 100_000: clk cycles each digit stays lit (1 ms at 100 MHz). Legal range is ≥ 2.
- `BLANK_LZ`, 1: when 1, leading zero digits are blanked; digit 0 is always shown.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous assert, active-low (0 = reset).
- `score`  in  16  unsigned binary score from `block_controller`; may change on any cycle.
- `bcd`  out  20  committed BCD value, five nibbles; [3:0] = ones, [19:16] = ten-thousands.
- `busy`  out  1  conversion in progress.
- `an`  out  8  anodes, active-low one-hot; an[7:5] are held at 1.
- `seg`  out  7  cathodes, active-low; bit0 = CA … bit6 = CG.
- `dp`  out  1  decimal point, active-low; always 1.

## Operation
Reset values: `bcd`=0, `busy`=0, `an`=8'hFF, `seg`=7'h7F, `dp`=1; internal `last_score`=0, digit index 0, refresh counter 0, FSM in IDLE.

Converter FSM (IDLE → SHIFT → COMMIT → IDLE):
- **IDLE**
  - If `score` != `last_score`: capture `score` into a 16-bit shift register, clear the 20-bit BCD accumulator, clear the bit counter, go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT**
  - Each cycle, add 3 to every accumulator nibble ≥ 5, then shift {acc, sreg} left by 1.
  - Bit counter 0..15; after the 16th shift go to COMMIT.
  - `busy`=1 only in this state.
- **COMMIT**
  - `bcd` ← accumulator, `last_score` ← captured value; go to IDLE.
- `score` changes during SHIFT/COMMIT are ignored. On return to IDLE the comparison repeats, so the latest value is always converted eventually.
- No score value overflows the accumulator; 65535 → 0x65535.

Scanner:
- Refresh counter counts 0..REFRESH_DIV-1 and wraps.
- On wrap, digit index advances 0→1→2→3→4→0.
- `an` and `seg` are registered together from the next index, on the same edge.
- Digit i is blank (`seg`=7'h7F, anode still driven) when BLANK_LZ=1, i>0, and nibbles i..4 of `bcd` are all 0.
- Decode table (active-low, g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Nibbles A–F (unreachable) → 7'h7F.
- The scanner reads only committed `bcd`, so no display tearing is possible.

## Timing
- Let edge E0 be the IDLE edge that sees a changed `score`.
  - SHIFT occupies E1..E16.
  - `bcd` is valid after E17.
  - Total latency is 18 cycles.
- `busy` rises after E0 and falls after E16.
- Back-to-back changes: the earliest next capture is E18, one IDLE cycle after COMMIT.
- Digit dwell is exactly REFRESH_DIV cycles; a full frame is 5·REFRESH_DIV cycles.
- Updating `bcd` mid-dwell changes `seg` on the next refresh wrap, not immediately.
- Reset asserted mid-conversion: all state returns to reset values immediately (async). After release, `score` ≠ 0 triggers a fresh conversion.
- Reset release is synchronized internally (2-flop) before the FSM leaves IDLE.

## Structure
- Package `score_display_pkg`:
  - FSM state enum (IDLE, SHIFT, COMMIT).
  - `SEG_BLANK`=7'h7F.
  - Seven-segment decode function.
  - `NUM_DIGITS`=5.
- Sub-module `bin2bcd_seq` holds the converter FSM, shift register, accumulator and counter.
  - Ports: clk, rst, bin[15:0], busy, bcd[19:0].
- The top holds the refresh counter, digit index, blanking logic and output registers.

## Test plan
1. Reset with `score`=0, REFRESH_DIV=4.
   - Outputs stay at their reset values while reset is held.
   - After release, `an` cycles FE→FD→FB→F7→EF, each for 4 cycles.
   - `seg`=40 on digit 0 and 7F on digits 1–4.
   - `busy` never rises.
2. `score`=12345.
   - `busy` high for exactly 16 cycles.
   - `bcd`=0x12345 at E17.
   - `seg` shows 79,24,30,19,12 on digits 4..0.
3. `score`=65535 → `bcd`=0x65535.
   - `score`=100 → `bcd`=0x00100; digits 3 and 4 blank, digit 2 shows 79.
4. `score` 7→9 changed at E5 of the conversion for 7.
   - `bcd`=0x00007 at E17, then 0x00009 by E35.
   - No other intermediate value appears.
5. Assert reset at E8 of the conversion for 500.
   - `bcd`=0, `busy`=0 and `an`=FF asynchronously.
   - After release, `bcd`=0x00500 within 20 cycles.
6. BLANK_LZ=0, `score`=42 → digits 4..0 show 40,40,40,19,24.
